chip8_timer_ctrl: RTL
=====================

# chip8_timer_ctrl

Owns the CHIP-8 delay timer (DT) and sound timer (ST) and sequences their 60 Hz decrement from the single system clock. Contains the 60 Hz tick prescaler, both 8-bit down-counters, and the write-versus-decrement arbitration. Serves CPU writes (`LD DT,Vx`, `LD ST,Vx`) and reads (`LD Vx,DT`), and drives the buzzer enable. Sits between the CPU execute stage and the audio output.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `TICK_HZ`, default 60: timer decrement rate.
- `DIV` (localparam) = `CLK_HZ/TICK_HZ`. Requires `DIV >= 2`.
- `clk` in, 1: system clock. Everything is on its rising edge.
- `reset` in, 1: synchronous, active-low. 0 = reset.
- `halt` in, 1: debug freeze. Freezes the prescaler and suppresses ticks.
- `dt_we` in, 1: load DT from `wdata`.
- `st_we` in, 1: load ST from `wdata`.
- `wdata` in, 8: value to load.
- `dt_value` out, 8: current DT (registered).
- `st_value` out, 8: current ST (registered).
- `sound_on` out, 1: high while ST != 0.
- `tick_60` out, 1: one-cycle pulse on each decrement opportunity.
- `dt_expired` out, 1: one-cycle pulse when DT reaches 0 by decrement.

## Operation
**Prescaler**
- `pcnt` counts 0..DIV-1 when `halt`=0, then wraps to 0.
- `tick_60` = 1 in the cycle where `pcnt == DIV-1` and `halt`=0.
- `halt`=1: `pcnt` holds its value and `tick_60` = 0.

**Each timer register (DT, ST), per cycle, by priority:**
1. Write enable asserted: load `wdata`.
2. `tick_60`=1 and value != 0: decrement by 1.
3. Otherwise: hold.

**Rules**
- A value of 0 never wraps to 255; it stays 0 on tick.
- `dt_we` and `st_we` asserted together: both load the same `wdata`, independently.
- Writes are accepted during `halt`.
- `sound_on` is a registered output: it equals (next ST != 0), so it is aligned with `st_value`.
- `dt_expired`: registered. It pulses the cycle `dt_value` becomes 0 through rule 2.
  - A write of 0 does not produce it.
  - A write that overrides a 1→0 decrement does not produce it.
- Arithmetic is 8-bit unsigned. `pcnt` width is `$clog2(DIV)`.

## Timing
- **Reset (`reset`=0 at a clock edge):**
  - `pcnt`=0, `dt_value`=0, `st_value`=0.
  - `sound_on`=0, `tick_60`=0, `dt_expired`=0.
  - Reset overrides any write in the same cycle.
- **First tick after reset:** with `reset`=1 from cycle 0 and `halt`=0, the first `tick_60` is in cycle DIV-1. Subsequent ticks follow every DIV cycles.
- **Reset mid-count:** it aborts the tick period in progress, with no partial-period credit.
- **Write latency:** a write in cycle N is visible on `dt_value`/`st_value`/`sound_on` in cycle N+1.
- **Write and tick in the same cycle:** the write wins, and the loaded value is not decremented. Its first decrement is at the next tick, so a value of V reaches 0 after V further ticks.
- **Decrement latency:** `tick_60` in cycle N → new value in cycle N+1. `dt_expired` is high in cycle N+1.
- **`halt` deasserted:** the prescaler resumes from the held `pcnt`. The remaining period is preserved.

## Structure
- Package `chip8_timer_pkg` holds:
  - `typedef logic [7:0] timer_t`
  - `localparam int unsigned TIMER_TICK_HZ = 60`
  - function `calc_div(clk_hz, tick_hz)`
- Sub-module `chip8_tick_gen`:
  - Parameter: `DIV`.
  - Ports: `clk`, `reset`, `halt`, `tick`.
  - Instantiated once.
- Both timer channels live in `chip8_timer_ctrl`, as one `always_ff` per channel.

## Test plan
Simulation uses CLK_HZ=600, TICK_HZ=60, so DIV=10.
1. **Reset:** hold `reset`=0 for 3 cycles → all outputs 0. Release → first `tick_60` at cycle 9, then at 19 and 29.
2. **DT countdown:** `dt_we`=1, `wdata`=8 for 1 cycle → `dt_value`=8 next cycle.
   - It decrements once per tick and reaches 0 after 8 ticks, with a single `dt_expired` pulse.
   - It stays 0 after further ticks.
3. **Sound:** `st_we` with `wdata`=3 → `sound_on`=1 the next cycle. After 3 ticks, `st_value`=0 and `sound_on`=0.
4. **Collision:** `dt_we`, `wdata`=5 in the same cycle as `tick_60`, with DT=1 beforehand.
   - `dt_value`=5 next cycle and no `dt_expired`.
   - It reaches 0 at the 5th subsequent tick.
5. **Halt:** assert `halt` at `pcnt`=4 for 20 cycles → no ticks and values frozen. A `dt_we` of 7 during `halt` loads. After release, the next tick is 5 cycles later.
6. **Reset mid-operation:** DT=200, ST=50. Pulse `reset`=0 together with `dt_we` → both timers 0, `sound_on`=0. The next tick is 10 cycles after release.

Source files
------------

// File: rtl/chip8_timer_pkg.sv
// chip8_timer_pkg: shared types and helpers for the CHIP-8 delay/sound timer block.
//   timer_t        - 8-bit unsigned timer register value
//   TIMER_TICK_HZ  - nominal CHIP-8 timer decrement rate
//   calc_div()     - system clocks per timer tick
package chip8_timer_pkg;

  typedef logic [7:0] timer_t;

  localparam int unsigned TIMER_TICK_HZ = 60;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/chip8_tick_gen.sv
// chip8_tick_gen: free-running prescaler producing a one-cycle tick every DIV
// clocks. The count freezes while halt is high, so the remaining period
// survives a debug freeze.
//   clk   - system clock (rising edge)
//   reset - synchronous, active-low
//   halt  - freeze count and suppress tick
//   tick  - one-cycle pulse when the count is at DIV-1 and not halted
module chip8_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic halt,
  output logic tick
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (!halt) begin
      pcnt <= (pcnt == LAST) ? '0 : pcnt + PW'(1);
    end
  end

  // Gated by reset so no tick is reported in a cycle that is being reset.
  assign tick = reset && !halt && (pcnt == LAST);

endmodule

// File: rtl/chip8_timer_ctrl.sv
// chip8_timer_ctrl: CHIP-8 delay timer (DT) and sound timer (ST).
// Both 8-bit counters load on CPU write, otherwise decrement on each 60 Hz tick
// until they reach 0 (no wrap). A write always beats a same-cycle decrement.
//   clk        - system clock (rising edge)
//   reset      - synchronous, active-low
//   halt       - debug freeze of the prescaler; writes still accepted
//   dt_we      - load DT from wdata
//   st_we      - load ST from wdata
//   wdata      - load value
//   dt_value   - registered DT
//   st_value   - registered ST
//   sound_on   - registered, high while ST != 0
//   tick_60    - one-cycle decrement-opportunity pulse
//   dt_expired - registered pulse when DT reaches 0 by decrement
module chip8_timer_ctrl
  import chip8_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = TIMER_TICK_HZ
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       halt,
  input  logic       dt_we,
  input  logic       st_we,
  input  logic [7:0] wdata,
  output logic [7:0] dt_value,
  output logic [7:0] st_value,
  output logic       sound_on,
  output logic       tick_60,
  output logic       dt_expired
);

  // DIV must be at least 2 for the prescaler to produce distinct ticks.
  localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);

  timer_t dt_q;
  timer_t st_q;

  chip8_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .halt (halt),
    .tick (tick_60)
  );

  // Delay timer channel. dt_expired only fires on the 1 -> 0 decrement path,
  // never on a write (including a write that overrides that decrement).
  always_ff @(posedge clk) begin
    if (!reset) begin
      dt_q       <= '0;
      dt_expired <= 1'b0;
    end else if (dt_we) begin
      dt_q       <= wdata;
      dt_expired <= 1'b0;
    end else if (tick_60 && (dt_q != '0)) begin
      dt_q       <= dt_q - timer_t'(1);
      dt_expired <= (dt_q == timer_t'(1));
    end else begin
      dt_expired <= 1'b0;
    end
  end

  // Sound timer channel. sound_on tracks the next ST value so it stays
  // cycle-aligned with st_value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q     <= '0;
      sound_on <= 1'b0;
    end else if (st_we) begin
      st_q     <= wdata;
      sound_on <= (wdata != '0);
    end else if (tick_60 && (st_q != '0)) begin
      st_q     <= st_q - timer_t'(1);
      sound_on <= (st_q != timer_t'(1));
    end else begin
      sound_on <= (st_q != '0);
    end
  end

  assign dt_value = dt_q;
  assign st_value = st_q;

endmodule
